// File: rtl/fb_fill_pkg.sv
// Shared types and constants for the framebuffer fill engine.
// Holds the FSM state encoding, default widths and the full write mask.
package fb_fill_pkg;

    localparam int FILL_ADDR_BITS   = 24;
    localparam int FILL_DIM_BITS    = 11;
    localparam int FILL_STRIDE_BITS = 12;

    localparam logic [1:0] FILL_WMASK_ALL = 2'b11;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_ISSUE,
        FILL_FINISH
    } fill_state_t;

endpackage

// File: rtl/fb_fill_addr_gen.sv
// Walks a WxH rectangle one word per accepted command, tracking column, row and row base.
// Presents the address of the word after the current one, plus a flag for the final word.
import fb_fill_pkg::*;

module fb_fill_addr_gen #(
    parameter int ADDR_BITS   = FILL_ADDR_BITS,
    parameter int DIM_BITS    = FILL_DIM_BITS,
    parameter int STRIDE_BITS = FILL_STRIDE_BITS
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   load_i,
    input  logic                   advance_i,
    input  logic [ADDR_BITS-1:0]   base_addr_i,
    input  logic [STRIDE_BITS-1:0] stride_i,
    input  logic [DIM_BITS-1:0]    width_i,
    input  logic [DIM_BITS-1:0]    height_i,
    output logic [ADDR_BITS-1:0]   next_addr_o,
    output logic                   last_word_o
);

    logic [DIM_BITS-1:0]  x_q;
    logic [DIM_BITS-1:0]  y_q;
    logic [ADDR_BITS-1:0] rowBase_q;

    logic                 lastCol;
    logic [DIM_BITS-1:0]  xNext;
    logic [ADDR_BITS-1:0] rowStep;

    // Address arithmetic wraps modulo 2^ADDR_BITS; stride and column are zero-extended.
    always_comb begin
        lastCol     = (x_q == (width_i - DIM_BITS'(1)));
        xNext       = x_q + DIM_BITS'(1);
        rowStep     = rowBase_q + ADDR_BITS'(stride_i);
        next_addr_o = lastCol ? rowStep : (rowBase_q + ADDR_BITS'(xNext));
        last_word_o = lastCol && (y_q == (height_i - DIM_BITS'(1)));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            x_q       <= '0;
            y_q       <= '0;
            rowBase_q <= '0;
        end else if (load_i) begin
            x_q       <= '0;
            y_q       <= '0;
            rowBase_q <= base_addr_i;
        end else if (advance_i) begin
            if (lastCol) begin
                x_q       <= '0;
                y_q       <= y_q + DIM_BITS'(1);
                rowBase_q <= rowStep;
            end else begin
                x_q <= xNext;
            end
        end
    end

endmodule

// File: rtl/fb_fill_engine.sv
// SDRAM write-side DMA that fills a rectangle of 16-bit words with a constant value.
// Drives one arbiter requester port and pulses done_o once at completion or abort.
import fb_fill_pkg::*;

module fb_fill_engine #(
    parameter int ADDR_BITS   = FILL_ADDR_BITS,
    parameter int DIM_BITS    = FILL_DIM_BITS,
    parameter int STRIDE_BITS = FILL_STRIDE_BITS
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [ADDR_BITS-1:0]   base_addr_i,
    input  logic [STRIDE_BITS-1:0] stride_i,
    input  logic [DIM_BITS-1:0]    width_i,
    input  logic [DIM_BITS-1:0]    height_i,
    input  logic [15:0]            fill_value_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   sdram_cmd_valid,
    input  logic                   sdram_cmd_ready,
    output logic                   sdram_wr,
    output logic [ADDR_BITS-1:0]   sdram_addr_x16,
    output logic [15:0]            sdram_wdata,
    output logic [1:0]             sdram_wmask
);

    fill_state_t            state_q;
    logic [STRIDE_BITS-1:0] stride_q;
    logic [DIM_BITS-1:0]    width_q;
    logic [DIM_BITS-1:0]    height_q;
    logic                   abortPending_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   valid_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [15:0]            wdata_q;
    logic [1:0]             wmask_q;

    logic                   load;
    logic                   accept;
    logic [ADDR_BITS-1:0]   nextAddr;
    logic                   lastWord;

    assign load   = (state_q == FILL_IDLE) && start_i;
    assign accept = (state_q == FILL_ISSUE) && valid_q && sdram_cmd_ready;

    fb_fill_addr_gen #(
        .ADDR_BITS   (ADDR_BITS),
        .DIM_BITS    (DIM_BITS),
        .STRIDE_BITS (STRIDE_BITS)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (load),
        .advance_i   (accept),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_q),
        .width_i     (width_q),
        .height_i    (height_q),
        .next_addr_o (nextAddr),
        .last_word_o (lastWord)
    );

    // A zero-sized fill passes through FINISH twice: one busy cycle, then the done cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= FILL_IDLE;
            stride_q       <= '0;
            width_q        <= '0;
            height_q       <= '0;
            abortPending_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            valid_q        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wmask_q        <= '0;
        end else begin
            case (state_q)
                FILL_IDLE: begin
                    done_q         <= 1'b0;
                    abortPending_q <= 1'b0;
                    if (start_i) begin
                        stride_q <= stride_i;
                        width_q  <= width_i;
                        height_q <= height_i;
                        wdata_q  <= fill_value_i;
                        busy_q   <= 1'b1;
                        if ((width_i == '0) || (height_i == '0)) begin
                            state_q <= FILL_FINISH;
                        end else begin
                            state_q <= FILL_ISSUE;
                            valid_q <= 1'b1;
                            addr_q  <= base_addr_i;
                            wmask_q <= FILL_WMASK_ALL;
                        end
                    end
                end
                FILL_ISSUE: begin
                    if (accept) begin
                        if (lastWord || abort_i || abortPending_q) begin
                            state_q        <= FILL_FINISH;
                            valid_q        <= 1'b0;
                            wmask_q        <= '0;
                            busy_q         <= 1'b0;
                            done_q         <= 1'b1;
                            abortPending_q <= 1'b0;
                        end else begin
                            addr_q <= nextAddr;
                        end
                    end else if (abort_i) begin
                        abortPending_q <= 1'b1;
                    end
                end
                FILL_FINISH: begin
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= FILL_IDLE;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FILL_IDLE;
                end
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign sdram_cmd_valid = valid_q;
    assign sdram_wr        = valid_q;
    assign sdram_addr_x16  = addr_q;
    assign sdram_wdata     = wdata_q;
    assign sdram_wmask     = wmask_q;

endmodule

// File: tb/tb_fb_fill_engine.sv
// Directed bench for fb_fill_engine: normal fills, backpressure, empty fills, wrap, abort and reset.
// Expected addresses come from base + row*stride + col, evaluated independently of the DUT.
module tb_fb_fill_engine;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic        abort_i;
    logic [23:0] base_addr_i;
    logic [11:0] stride_i;
    logic [10:0] width_i;
    logic [10:0] height_i;
    logic [15:0] fill_value_i;
    logic        busy_o;
    logic        done_o;
    logic        sdram_cmd_valid;
    logic        sdram_cmd_ready;
    logic        sdram_wr;
    logic [23:0] sdram_addr_x16;
    logic [15:0] sdram_wdata;
    logic [1:0]  sdram_wmask;

    int          errors = 0;
    int          checks = 0;
    logic [23:0] lastAddr;

    always #5 clk_i = ~clk_i;

    fb_fill_engine dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .base_addr_i     (base_addr_i),
        .stride_i        (stride_i),
        .width_i         (width_i),
        .height_i        (height_i),
        .fill_value_i    (fill_value_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .sdram_cmd_valid (sdram_cmd_valid),
        .sdram_cmd_ready (sdram_cmd_ready),
        .sdram_wr        (sdram_wr),
        .sdram_addr_x16  (sdram_addr_x16),
        .sdram_wdata     (sdram_wdata),
        .sdram_wmask     (sdram_wmask)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents parameters with a one-cycle start strobe; optionally raises abort in the same cycle.
    task automatic applyStimulus(input logic [23:0] base, input logic [11:0] stride,
                                 input logic [10:0] w, input logic [10:0] h,
                                 input logic [15:0] fill, input logic withAbort);
        base_addr_i  = base;
        stride_i     = stride;
        width_i      = w;
        height_i     = h;
        fill_value_i = fill;
        start_i      = 1'b1;
        abort_i      = withAbort;
        tick();
        start_i      = 1'b0;
        abort_i      = 1'b0;
    endtask

    // readyMode: 0 = always ready, 1 = random ready, 2 = ready dropped for 3 cycles once abort is raised.
    task automatic runFill(input string tag, input logic [23:0] base, input logic [11:0] stride,
                           input logic [10:0] w, input logic [10:0] h, input logic [15:0] fill,
                           input logic withAbort, input int readyMode, input int abortAfter,
                           input int expCount, input int expDoneCycle);
        int          k = 0;
        int          doneCnt = 0;
        int          doneCyc = 0;
        int          holdCnt = 0;
        bit          abortSent = 0;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [23:0] pa = '0;
        logic [23:0] ea;
        applyStimulus(base, stride, w, h, fill, withAbort);
        checkOutput({tag, "/firstValid"}, sdram_cmd_valid, (expCount > 0) ? 1 : 0);
        checkOutput({tag, "/busyStart"}, busy_o, 1);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (done_o) begin
                doneCnt++;
                doneCyc = cyc;
                checkOutput({tag, "/doneBusy"}, busy_o, 0);
            end
            if (doneCnt > 0) begin
                checkOutput({tag, "/validAfterDone"}, sdram_cmd_valid, 0);
                if (cyc >= doneCyc + 2) break;
            end
            if (sdram_cmd_valid) begin
                checkOutput({tag, "/wdata"}, sdram_wdata, fill);
                checkOutput({tag, "/wmask"}, sdram_wmask, 3);
                checkOutput({tag, "/wr"}, sdram_wr, 1);
            end
            if (pv && !pr) begin
                checkOutput({tag, "/holdValid"}, sdram_cmd_valid, 1);
                checkOutput({tag, "/holdAddr"}, sdram_addr_x16, pa);
            end
            if (abortAfter >= 0 && k == abortAfter && !abortSent) begin
                abort_i   = 1'b1;
                abortSent = 1;
            end else begin
                abort_i = 1'b0;
            end
            case (readyMode)
                0: sdram_cmd_ready = 1'b1;
                1: sdram_cmd_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (abortSent && holdCnt < 3) begin
                        sdram_cmd_ready = 1'b0;
                        holdCnt++;
                    end else begin
                        sdram_cmd_ready = 1'b1;
                    end
                end
            endcase
            if (sdram_cmd_valid && sdram_cmd_ready) begin
                ea = base + 24'(k / int'(w)) * 24'(stride) + 24'(k % int'(w));
                checkOutput({tag, "/addr"}, sdram_addr_x16, ea);
                lastAddr = sdram_addr_x16;
                k++;
            end
            pv = sdram_cmd_valid;
            pr = sdram_cmd_ready;
            pa = sdram_addr_x16;
            tick();
        end
        abort_i = 1'b0;
        sdram_cmd_ready = 1'b1;
        checkOutput({tag, "/cmdCount"}, k, expCount);
        checkOutput({tag, "/doneCount"}, doneCnt, 1);
        if (expDoneCycle >= 0)
            checkOutput({tag, "/doneCycle"}, doneCyc, expDoneCycle);
        checkOutput({tag, "/busyEnd"}, busy_o, 0);
    endtask

    initial begin
        rst_n_i         = 1'b0;
        start_i         = 1'b0;
        abort_i         = 1'b0;
        base_addr_i     = '0;
        stride_i        = '0;
        width_i         = '0;
        height_i        = '0;
        fill_value_i    = '0;
        sdram_cmd_ready = 1'b0;
        lastAddr        = '0;
        tick();
        tick();
        checkOutput("reset/valid", sdram_cmd_valid, 0);
        checkOutput("reset/wr", sdram_wr, 0);
        checkOutput("reset/busy", busy_o, 0);
        checkOutput("reset/done", done_o, 0);
        checkOutput("reset/addr", sdram_addr_x16, 0);
        checkOutput("reset/wdata", sdram_wdata, 0);
        checkOutput("reset/wmask", sdram_wmask, 0);
        rst_n_i = 1'b1;
        tick();

        $display("[TB] T1 contiguous fill");
        runFill("T1", 24'h000100, 12'd320, 11'd4, 11'd2, 16'hABCD, 1'b0, 0, -1, 8, 9);
        checkOutput("T1/lastAddr", lastAddr, 24'h000243);

        $display("[TB] T2 random backpressure");
        runFill("T2", 24'h000100, 12'd320, 11'd4, 11'd2, 16'hABCD, 1'b0, 1, -1, 8, -1);
        checkOutput("T2/lastAddr", lastAddr, 24'h000243);

        $display("[TB] T3 empty rectangles");
        runFill("T3a", 24'h000200, 12'd16, 11'd0, 11'd5, 16'h1111, 1'b0, 0, -1, 0, 2);
        runFill("T3b", 24'h000200, 12'd16, 11'd5, 11'd0, 16'h2222, 1'b0, 0, -1, 0, 2);

        $display("[TB] T4 address wrap, start with abort");
        runFill("T4", 24'hFFFFFE, 12'd4, 11'd4, 11'd1, 16'h5A5A, 1'b1, 0, -1, 4, 5);
        checkOutput("T4/lastAddr", lastAddr, 24'h000001);

        $display("[TB] T5 abort with held command");
        runFill("T5", 24'h010000, 12'd64, 11'd16, 11'd16, 16'hBEEF, 1'b0, 2, 3, 4, 8);
        checkOutput("T5/lastAddr", lastAddr, 24'h010003);

        $display("[TB] T6 reset mid-fill");
        applyStimulus(24'h001000, 12'd200, 11'd100, 11'd100, 16'h1234, 1'b0);
        sdram_cmd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start_i = (i == 2);
            if (i == 2) base_addr_i = 24'h999999;
            checkOutput("T6/busyStartAddr", sdram_addr_x16, 24'h001000 + 24'(i));
            tick();
        end
        start_i = 1'b0;
        rst_n_i = 1'b0;
        tick();
        checkOutput("T6/rstValid", sdram_cmd_valid, 0);
        checkOutput("T6/rstBusy", busy_o, 0);
        checkOutput("T6/rstDone", done_o, 0);
        rst_n_i = 1'b1;
        tick();
        checkOutput("T6/postRstDone", done_o, 0);
        runFill("T6new", 24'h005000, 12'd16, 11'd2, 11'd2, 16'h7777, 1'b0, 0, -1, 4, 5);
        checkOutput("T6new/lastAddr", lastAddr, 24'h005011);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
